// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles WIDTH strobed bits into a word and
// hands it off through a one-deep valid/ready output register with sticky overrun.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       serial_en,
  input  logic                       clear,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    RX_IDLE,
    RX_SHIFTING
  } rx_state_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  rx_state_t          rx_state;
  out_state_t         out_state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_next;
  logic [CW-1:0]      cnt;
  logic               completing;

  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST) begin
      shreg_next = {shreg[WIDTH-2:0], serial_in};
    end else begin
      shreg_next = {serial_in, shreg[WIDTH-1:1]};
    end
    completing = serial_en && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      out_state    <= OUT_EMPTY;
      shreg        <= '0;
      cnt          <= '0;
      parallel_out <= '0;
      overrun      <= 1'b0;
    end else if (clear) begin
      // Pending output word survives an abort; only the receive side is flushed.
      rx_state <= RX_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      overrun  <= 1'b0;
    end else begin
      if (serial_en) begin
        shreg <= shreg_next;
        if (completing) begin
          cnt      <= '0;
          rx_state <= RX_IDLE;
        end else begin
          cnt      <= cnt + CW'(1);
          rx_state <= RX_SHIFTING;
        end
      end

      if (completing) begin
        if (out_state == OUT_EMPTY || out_ready) begin
          parallel_out <= shreg_next;
          out_state    <= OUT_FULL;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_state == OUT_FULL && out_ready) begin
        out_state <= OUT_EMPTY;
      end
    end
  end

  assign out_valid = (out_state == OUT_FULL);
  assign bit_count = cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed-vector bench driving an MSB-first and an LSB-first instance in parallel.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_en = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] po_msb, po_lsb;
  logic       valid_msb, valid_lsb;
  logic       ovr_msb, ovr_lsb;
  logic [2:0] cnt_msb, cnt_lsb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
    .clear(clear), .parallel_out(po_msb), .out_valid(valid_msb),
    .out_ready(out_ready), .overrun(ovr_msb), .bit_count(cnt_msb)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
    .clear(clear), .parallel_out(po_lsb), .out_valid(valid_lsb),
    .out_ready(out_ready), .overrun(ovr_lsb), .bit_count(cnt_lsb)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic       en;
    logic       sin;
    logic       rdy;
    logic [3:0] e_msb;
    logic [3:0] e_lsb;
    logic       e_valid;
    logic       e_ovr;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   step_no = 0;

  function automatic vec_t v(logic rst, logic clr, logic en, logic sin, logic rdy,
                             logic [3:0] e_msb, logic [3:0] e_lsb,
                             logic e_valid, logic e_ovr, logic [2:0] e_cnt);
    vec_t r;
    r.rst = rst; r.clr = clr; r.en = en; r.sin = sin; r.rdy = rdy;
    r.e_msb = e_msb; r.e_lsb = e_lsb;
    r.e_valid = e_valid; r.e_ovr = e_ovr; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    reset     = t.rst;
    clear     = t.clr;
    serial_en = t.en;
    serial_in = t.sin;
    out_ready = t.rdy;
    @(posedge clk);
    #1;
    chk("po_msb",    32'(po_msb),    32'(t.e_msb));
    chk("po_lsb",    32'(po_lsb),    32'(t.e_lsb));
    chk("valid_msb", 32'(valid_msb), 32'(t.e_valid));
    chk("valid_lsb", 32'(valid_lsb), 32'(t.e_valid));
    chk("ovr_msb",   32'(ovr_msb),   32'(t.e_ovr));
    chk("ovr_lsb",   32'(ovr_lsb),   32'(t.e_ovr));
    chk("cnt_msb",   32'(cnt_msb),   32'(t.e_cnt));
    chk("cnt_lsb",   32'(cnt_lsb),   32'(t.e_cnt));
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // reset state
    vecs.push_back(v(1,0,0,0,0, 4'h0,4'h0,0,0,0));
    // word 1011, consecutive strobes, ready high
    vecs.push_back(v(0,0,1,1,1, 4'h0,4'h0,0,0,1));
    vecs.push_back(v(0,0,1,0,1, 4'h0,4'h0,0,0,2));
    vecs.push_back(v(0,0,1,1,1, 4'h0,4'h0,0,0,3));
    vecs.push_back(v(0,0,1,1,1, 4'hB,4'hD,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 4'hB,4'hD,0,0,0));
    // same bits with gaps 0,2,5; noise on serial_in during gaps
    vecs.push_back(v(0,0,1,1,1, 4'hB,4'hD,0,0,1));
    vecs.push_back(v(0,0,1,0,1, 4'hB,4'hD,0,0,2));
    for (int i = 0; i < 2; i++) vecs.push_back(v(0,0,0,1,1, 4'hB,4'hD,0,0,2));
    vecs.push_back(v(0,0,1,1,1, 4'hB,4'hD,0,0,3));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0,0,0,0,1, 4'hB,4'hD,0,0,3));
    vecs.push_back(v(0,0,1,1,1, 4'hB,4'hD,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 4'hB,4'hD,0,0,0));
    // ready low: word A then word 5 overruns
    vecs.push_back(v(0,0,1,1,0, 4'hB,4'hD,0,0,1));
    vecs.push_back(v(0,0,1,0,0, 4'hB,4'hD,0,0,2));
    vecs.push_back(v(0,0,1,1,0, 4'hB,4'hD,0,0,3));
    vecs.push_back(v(0,0,1,0,0, 4'hA,4'h5,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 4'hA,4'h5,1,0,1));
    vecs.push_back(v(0,0,1,1,0, 4'hA,4'h5,1,0,2));
    vecs.push_back(v(0,0,1,0,0, 4'hA,4'h5,1,0,3));
    vecs.push_back(v(0,0,1,1,0, 4'hA,4'h5,1,1,0));
    vecs.push_back(v(0,0,0,0,1, 4'hA,4'h5,0,1,0));
    vecs.push_back(v(0,0,0,0,0, 4'hA,4'h5,0,1,0));
    vecs.push_back(v(0,1,0,0,1, 4'hA,4'h5,0,0,0));
    // stream 3, C, F with ready held high
    vecs.push_back(v(0,0,1,0,1, 4'hA,4'h5,0,0,1));
    vecs.push_back(v(0,0,1,0,1, 4'hA,4'h5,0,0,2));
    vecs.push_back(v(0,0,1,1,1, 4'hA,4'h5,0,0,3));
    vecs.push_back(v(0,0,1,1,1, 4'h3,4'hC,1,0,0));
    vecs.push_back(v(0,0,1,1,1, 4'h3,4'hC,0,0,1));
    vecs.push_back(v(0,0,1,1,1, 4'h3,4'hC,0,0,2));
    vecs.push_back(v(0,0,1,0,1, 4'h3,4'hC,0,0,3));
    vecs.push_back(v(0,0,1,0,1, 4'hC,4'h3,1,0,0));
    vecs.push_back(v(0,0,1,1,1, 4'hC,4'h3,0,0,1));
    vecs.push_back(v(0,0,1,1,1, 4'hC,4'h3,0,0,2));
    vecs.push_back(v(0,0,1,1,1, 4'hC,4'h3,0,0,3));
    vecs.push_back(v(0,0,1,1,1, 4'hF,4'hF,1,0,0));
    // completion while full with ready on the same edge replaces the word
    vecs.push_back(v(0,0,1,0,0, 4'hF,4'hF,1,0,1));
    vecs.push_back(v(0,0,1,1,0, 4'hF,4'hF,1,0,2));
    vecs.push_back(v(0,0,1,1,0, 4'hF,4'hF,1,0,3));
    vecs.push_back(v(0,0,1,0,1, 4'h6,4'h6,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 4'h6,4'h6,0,0,0));

    foreach (vecs[i]) step(vecs[i]);

    // clear mid-word with a strobed bit on the same edge, then word 9
    step(v(0,0,1,1,1, 4'h6,4'h6,0,0,1));
    step(v(0,0,1,0,1, 4'h6,4'h6,0,0,2));
    step(v(0,1,1,1,1, 4'h6,4'h6,0,0,0));
    step(v(0,0,1,1,1, 4'h6,4'h6,0,0,1));
    step(v(0,0,1,0,1, 4'h6,4'h6,0,0,2));
    step(v(0,0,1,0,1, 4'h6,4'h6,0,0,3));
    step(v(0,0,1,1,1, 4'h9,4'h9,1,0,0));
    // overrun with word pending, then clear keeps the pending word
    step(v(0,0,1,0,0, 4'h9,4'h9,1,0,1));
    step(v(0,0,1,0,0, 4'h9,4'h9,1,0,2));
    step(v(0,0,1,0,0, 4'h9,4'h9,1,0,3));
    step(v(0,0,1,0,0, 4'h9,4'h9,1,1,0));
    step(v(0,1,0,0,0, 4'h9,4'h9,1,0,0));

    // reset after 3 bits with a word pending, then word 6
    step(v(0,0,1,1,0, 4'h9,4'h9,1,0,1));
    step(v(0,0,1,1,0, 4'h9,4'h9,1,0,2));
    step(v(0,0,1,1,0, 4'h9,4'h9,1,0,3));
    step(v(1,0,1,1,0, 4'h0,4'h0,0,0,0));
    step(v(0,0,1,0,1, 4'h0,4'h0,0,0,1));
    step(v(0,0,1,1,1, 4'h0,4'h0,0,0,2));
    step(v(0,0,1,1,1, 4'h0,4'h0,0,0,3));
    step(v(0,0,1,0,1, 4'h6,4'h6,1,0,0));
    step(v(0,0,0,0,1, 4'h6,4'h6,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
